// File: rtl/snd_access_seq.sv
// snd_access_seq: timed YM2203 x2 / SAA1099 access cycles on the internal bus.
// Define TFM_SEQ_PENDING_EN to add a one-entry pending request buffer.
module snd_access_seq #(
  parameter int YM_SETUP  = 1,
  parameter int YM_PULSE  = 14,
  parameter int YM_HOLD   = 2,
  parameter int SAA_CS2WR = 3,
  parameter int SAA_PULSE = 6,
  parameter int SAA_HOLD  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_wraddr,
  input  logic       req_wrdata,
  input  logic       req_rddata,
  input  logic       req_cfg,
  input  logic [7:0] wdata,
  input  logic       ym_sel,
  input  logic       ym_stat,
  input  logic       saa_ena,
  input  logic [7:0] d_in,
  output logic [7:0] d_out,
  output logic       d_oe,
  output logic       yma0,
  output logic       ymcs0_n,
  output logic       ymcs1_n,
  output logic       ymrd_n,
  output logic       ymwr_n,
  output logic       saaa0,
  output logic       saacs_n,
  output logic       saawr_n,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       drop
);

  localparam int M1 = (YM_SETUP > YM_PULSE) ? YM_SETUP : YM_PULSE;
  localparam int M2 = (YM_HOLD > SAA_CS2WR) ? YM_HOLD : SAA_CS2WR;
  localparam int M3 = (SAA_PULSE > SAA_HOLD) ? SAA_PULSE : SAA_HOLD;
  localparam int M4 = (M1 > M2) ? M1 : M2;
  localparam int MX = (M4 > M3) ? M4 : M3;
  localparam int CW = (MX < 2) ? 1 : $clog2(MX);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  typedef struct packed {
    logic       saa;
    logic       rd;
    logic       sel;
    logic       a0;
    logic [7:0] d;
  } desc_t;

  function automatic logic [CW-1:0] len_m1(state_t s, logic saa);
    int n;
    n = 1;
    case (s)
      SETUP:   n = saa ? SAA_CS2WR : YM_SETUP;
      STROBE:  n = saa ? SAA_PULSE : YM_PULSE;
      HOLD:    n = saa ? SAA_HOLD  : YM_HOLD;
      default: n = 1;
    endcase
    return CW'(n - 1);
  endfunction

  state_t        r_state, w_nstate;
  logic [CW-1:0] r_cnt, w_ncnt;
  desc_t         r_desc, w_ndesc, w_new, w_pend;
  logic          r_yma0, r_saaa0, r_rd_valid, r_drop;
  logic [7:0]    r_rd_data;
  logic          w_req_rd, w_req_wd, w_req_wa;
  logic          w_saa_rd, w_chip, w_busy, w_last;
  logic          w_load, w_store, w_drop, w_cap, w_pend_v;

  assign w_req_rd = req_rddata;
  assign w_req_wd = req_wrdata & ~req_rddata;
  assign w_req_wa = req_wraddr & ~req_wrdata & ~req_rddata & ~req_cfg;
  assign w_saa_rd = w_req_rd & saa_ena;
  assign w_chip   = w_req_wd | w_req_wa | (w_req_rd & ~saa_ena);

  assign w_new.saa = saa_ena;
  assign w_new.rd  = w_req_rd;
  assign w_new.sel = ym_sel;
  assign w_new.a0  = w_req_rd ? ~ym_stat : (w_req_wd ^ saa_ena);
  assign w_new.d   = wdata;

  assign w_busy = (r_state != IDLE);
  assign w_last = (r_cnt == '0);
  assign w_cap  = (r_state == STROBE) & w_last & r_desc.rd & ~r_desc.saa;

`ifdef TFM_SEQ_PENDING_EN
  logic  r_pend_v;
  desc_t r_pend;
  logic  w_hold_end, w_pop;

  assign w_hold_end = (r_state == HOLD) & w_last;
  assign w_pop      = w_hold_end & r_pend_v;
  assign w_pend_v   = r_pend_v;
  assign w_pend     = r_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_v <= 1'b0;
      r_pend   <= '0;
    end else if (w_store) begin
      r_pend_v <= 1'b1;
      r_pend   <= w_new;
    end else if (w_pop) begin
      r_pend_v <= 1'b0;
    end
  end
`else
  assign w_pend_v = 1'b0;
  assign w_pend   = '0;
`endif

  always_comb begin
    w_nstate = r_state;
    w_ndesc  = r_desc;
    w_load   = 1'b0;
    w_store  = 1'b0;
    w_drop   = 1'b0;
    case (r_state)
      IDLE: if (w_chip) begin
        w_nstate = SETUP;
        w_ndesc  = w_new;
        w_load   = 1'b1;
      end
      SETUP:  if (w_last) w_nstate = STROBE;
      STROBE: if (w_last) w_nstate = HOLD;
      HOLD: if (w_last) begin
        w_nstate = IDLE;
        if (w_pend_v) begin
          w_nstate = SETUP;
          w_ndesc  = w_pend;
          w_load   = 1'b1;
        end
`ifdef TFM_SEQ_PENDING_EN
        else if (w_chip) begin
          w_nstate = SETUP;
          w_ndesc  = w_new;
          w_load   = 1'b1;
        end
`endif
      end
      default: w_nstate = IDLE;
    endcase
    if (w_chip && w_busy) begin
`ifdef TFM_SEQ_PENDING_EN
      if (w_pend_v)
        w_drop = 1'b1;
      else if (!w_hold_end)
        w_store = 1'b1;
`else
      w_drop = 1'b1;
`endif
    end
    if (w_nstate != r_state || w_load)
      w_ncnt = len_m1(w_nstate, w_ndesc.saa);
    else if (w_busy)
      w_ncnt = r_cnt - CW'(1);
    else
      w_ncnt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_desc     <= '0;
      r_yma0     <= 1'b0;
      r_saaa0    <= 1'b0;
      r_rd_data  <= 8'hFF;
      r_rd_valid <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_state    <= w_nstate;
      r_cnt      <= w_ncnt;
      r_rd_valid <= 1'b0;
      if (w_load) begin
        r_desc <= w_ndesc;
        if (w_ndesc.saa) r_saaa0 <= w_ndesc.a0;
        else             r_yma0  <= w_ndesc.a0;
      end
      if (w_cap) begin
        r_rd_data  <= d_in;
        r_rd_valid <= 1'b1;
      end
      // SAA has no readable port; answer with an idle-bus value
      if (w_saa_rd) begin
        r_rd_data  <= 8'hFF;
        r_rd_valid <= 1'b1;
      end
      if (w_drop) r_drop <= 1'b1;
    end
  end

  assign d_out    = r_desc.d;
  assign d_oe     = w_busy & ~r_desc.rd;
  assign yma0     = r_yma0;
  assign saaa0    = r_saaa0;
  assign ymcs0_n  = ~(r_state == STROBE & ~r_desc.saa & ~r_desc.sel);
  assign ymcs1_n  = ~(r_state == STROBE & ~r_desc.saa & r_desc.sel);
  assign ymrd_n   = ~(r_state == STROBE & ~r_desc.saa & r_desc.rd);
  assign ymwr_n   = ~(r_state == STROBE & ~r_desc.saa & ~r_desc.rd);
  assign saacs_n  = ~(r_desc.saa & (r_state == SETUP | r_state == STROBE));
  assign saawr_n  = ~(r_desc.saa & r_state == STROBE);
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign busy     = w_busy;
  assign drop     = r_drop;

endmodule

// File: tb/tb_snd_access_seq.sv
// tb_snd_access_seq: random + directed stimulus against a cycle-offset
// reference model of the sound-chip access sequencer.
module tb_snd_access_seq;

  localparam int YS = 1, YP = 14, YH = 2;
  localparam int SS = 3, SP = 6, SH = 2;
`ifdef TFM_SEQ_PENDING_EN
  localparam bit PEND = 1'b1;
`else
  localparam bit PEND = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_wraddr = 0, req_wrdata = 0, req_rddata = 0, req_cfg = 0;
  logic [7:0] wdata = 0, d_in = 0;
  logic       ym_sel = 0, ym_stat = 0, saa_ena = 0;
  logic [7:0] d_out, rd_data;
  logic       d_oe, yma0, ymcs0_n, ymcs1_n, ymrd_n, ymwr_n;
  logic       saaa0, saacs_n, saawr_n, rd_valid, busy, drop;

  snd_access_seq dut (
    .clk(clk), .rst_n(rst_n),
    .req_wraddr(req_wraddr), .req_wrdata(req_wrdata),
    .req_rddata(req_rddata), .req_cfg(req_cfg),
    .wdata(wdata), .ym_sel(ym_sel), .ym_stat(ym_stat),
    .saa_ena(saa_ena), .d_in(d_in),
    .d_out(d_out), .d_oe(d_oe), .yma0(yma0),
    .ymcs0_n(ymcs0_n), .ymcs1_n(ymcs1_n),
    .ymrd_n(ymrd_n), .ymwr_n(ymwr_n),
    .saaa0(saaa0), .saacs_n(saacs_n), .saawr_n(saawr_n),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .drop(drop)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    bit         saa;
    bit         rd;
    bit         sel;
    bit         a0;
    logic [7:0] d;
  } mdesc_t;

  mdesc_t     m_cur;
  mdesc_t     m_q[$];
  bit         m_act, m_rdv, m_drop, m_yma0, m_saaa0;
  int         m_t;
  logic [7:0] m_rdd;

  function automatic int seg(bit saa, int k);
    if (k == 0) return saa ? SS : YS;
    if (k == 1) return saa ? SP : YP;
    return saa ? SH : YH;
  endfunction

  function automatic int phase();
    if (!m_act) return 0;
    if (m_t < seg(m_cur.saa, 0)) return 1;
    if (m_t < seg(m_cur.saa, 0) + seg(m_cur.saa, 1)) return 2;
    return 3;
  endfunction

  task automatic m_reset();
    m_act = 0; m_t = 0; m_rdv = 0; m_drop = 0;
    m_yma0 = 0; m_saaa0 = 0; m_rdd = 8'hFF;
    m_cur = '{saa: 0, rd: 0, sel: 0, a0: 0, d: 8'h00};
    m_q.delete();
  endtask

  task automatic m_launch(mdesc_t d);
    m_cur = d; m_act = 1; m_t = 0;
    if (d.saa) m_saaa0 = d.a0;
    else       m_yma0  = d.a0;
  endtask

  task automatic m_update();
    bit rd, wd, wa, chip, saard, start;
    int tot;
    mdesc_t nd;
    rd = req_rddata;
    wd = req_wrdata && !rd;
    wa = req_wraddr && !req_wrdata && !rd && !req_cfg;
    saard = rd && saa_ena;
    chip = wd || wa || (rd && !saa_ena);
    nd = '{saa: saa_ena, rd: rd, sel: ym_sel,
           a0: rd ? !ym_stat : (wd ? !saa_ena : saa_ena), d: wdata};
    start = 0;
    m_rdv = 0;
    if (chip) begin
      if (!m_act) start = 1;
      else if (PEND && m_q.size() == 0) m_q.push_back(nd);
      else m_drop = 1;
    end
    if (m_act) begin
      if (m_cur.rd && !m_cur.saa && m_t == YS + YP - 1) begin
        m_rdd = d_in; m_rdv = 1;
      end
      tot = seg(m_cur.saa, 0) + seg(m_cur.saa, 1) + seg(m_cur.saa, 2);
      m_t++;
      if (m_t == tot) begin
        m_act = 0;
        if (m_q.size() > 0) m_launch(m_q.pop_front());
      end
    end
    if (saard) begin
      m_rdd = 8'hFF; m_rdv = 1;
    end
    if (start) m_launch(nd);
  endtask

  task automatic compare_all();
    int ph;
    bit ym, sa;
    logic [5:0] es;
    ph = phase();
    ym = m_act && !m_cur.saa;
    sa = m_act && m_cur.saa;
    es[5] = !(ym && ph == 2 && !m_cur.sel);
    es[4] = !(ym && ph == 2 && m_cur.sel);
    es[3] = !(ym && ph == 2 && m_cur.rd);
    es[2] = !(ym && ph == 2 && !m_cur.rd);
    es[1] = !(sa && (ph == 1 || ph == 2));
    es[0] = !(sa && ph == 2);
    chk("strobes", {ymcs0_n, ymcs1_n, ymrd_n, ymwr_n, saacs_n, saawr_n}, es);
    chk("a0", {yma0, saaa0}, {m_yma0, m_saaa0});
    chk("d_oe", d_oe, m_act && !m_cur.rd);
    if (m_act && !m_cur.rd) chk("d_out", d_out, m_cur.d);
    chk("rd", {rd_valid, rd_data}, {m_rdv, m_rdd});
    chk("busy_drop", {busy, drop}, {m_act, m_drop});
  endtask

  task automatic step(input bit wa, input bit wd, input bit rd,
                      input bit cfg, input logic [7:0] wv,
                      input bit sel, input bit stat, input bit saa);
    @(negedge clk);
    compare_all();
    req_wraddr = wa; req_wrdata = wd; req_rddata = rd; req_cfg = cfg;
    wdata = wv; ym_sel = sel; ym_stat = stat; saa_ena = saa;
    d_in = 8'($urandom);
    @(posedge clk);
    m_update();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(0, 0, 0, 0, 8'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom));
  endtask

  initial begin
    int k;
    m_reset();
    #12;
    chk("rst_strobes", {ymcs0_n, ymcs1_n, ymrd_n, ymwr_n, saacs_n, saawr_n},
        6'b111111);
    chk("rst_bus", {d_oe, d_out, yma0, saaa0}, 11'h0);
    chk("rst_rd", {rd_valid, rd_data}, 9'h0FF);
    chk("rst_busy_drop", {busy, drop}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    step(1, 0, 0, 0, 8'h27, 1, 0, 0);
    idle(20);
    step(0, 0, 1, 0, 8'h00, 0, 0, 0);
    idle(20);
    step(0, 1, 0, 0, 8'h1C, 0, 0, 1);
    idle(14);
    step(0, 0, 1, 0, 8'h00, 0, 0, 1);
    idle(3);
    step(1, 0, 0, 1, 8'h55, 0, 0, 0);
    idle(3);
    chk("drop_pre", drop, 1'b0);

    step(1, 0, 0, 0, 8'h11, 0, 0, 0);
    idle(4);
    step(0, 1, 0, 0, 8'h22, 1, 0, 0);
    idle(2);
    step(1, 0, 0, 0, 8'h33, 0, 0, 1);
    idle(40);
    chk("drop_seq", drop, 1'b1);

    step(1, 0, 0, 0, 8'h6B, 0, 0, 0);
    k = 0;
    while (phase() != 2 && k < 40) begin
      idle(1);
      k++;
    end
    idle(3);
    chk("wait_strobe", phase(), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_strobes", {ymcs0_n, ymcs1_n, ymrd_n, ymwr_n, saacs_n, saawr_n},
        6'b111111);
    chk("arst_oe_rd", {d_oe, rd_data}, 9'h0FF);
    chk("arst_busy", busy, 1'b0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(10);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 5))
          0: step(1, 0, 0, 0, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
          1: step(0, 1, 0, 0, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
          2: step(0, 0, 1, 0, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
          3: step(1, 0, 0, 1, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
          4: step(1, 1, 1, 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
          default: step(1, 1, 0, 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        endcase
      end else begin
        idle(1);
      end
    end
    idle(30);

    $display("%0d/%0d checks passed", n_chk - n_err, n_chk);
    $finish;
  end

endmodule
